// File: rtl/dbus_ctrl.sv
// dbus_ctrl: single-outstanding data-bus controller for the memory stage.
// Turns load/store requests into bus transactions and returns aligned, extended load data.
module dbus_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [63:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [63:0]      req_wdata,
    input  logic             flush,
    output logic             stall,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [63:0]      rsp_rdata,
    output logic             dreq_valid,
    output logic [63:0]      dreq_addr,
    output logic [7:0]       dreq_strobe,
    output logic [63:0]      dreq_data,
    input  logic             dresp_addr_ok,
    input  logic             dresp_data_ok,
    input  logic [63:0]      dresp_data,
    output logic [CNT_W-1:0] busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic res;
        case (size)
            2'd0:    res = 1'b0;
            2'd1:    res = (off[0] != 1'b0);
            2'd2:    res = (off[1:0] != 2'b00);
            2'd3:    res = (off != 3'b000);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] f_strobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            2'd3:    base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] f_load_extend(input logic [63:0] data, input logic [2:0] off,
                                                  input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [63:0] res;
        sh = data >> {off, 3'b000};
        case (size)
            2'd0:    res = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'd1:    res = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'd2:    res = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_misaligned;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [2:0]        r_off;
    logic              r_discard;
    logic              r_dreq_valid;
    logic [63:0]       r_dreq_addr;
    logic [7:0]        r_dreq_strobe;
    logic [63:0]       r_dreq_data;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [63:0]       r_rsp_rdata;
    logic [CNT_W-1:0]  r_busy;

    // Next-state decode.
    always_comb begin
        w_misaligned = f_misaligned(req_size, req_addr[2:0]);
        w_accept     = req_valid & ~flush;
        w_next       = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_misaligned ? S_DONE : S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (dresp_addr_ok) begin
                    w_next = dresp_data_ok ? S_DONE : S_WAIT;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture, bus request registers and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_write       <= 1'b0;
            r_size        <= 2'd0;
            r_unsigned    <= 1'b0;
            r_off         <= 3'd0;
            r_discard     <= 1'b0;
            r_dreq_valid  <= 1'b0;
            r_dreq_addr   <= 64'd0;
            r_dreq_strobe <= 8'd0;
            r_dreq_data   <= 64'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= 64'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[2:0];
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 64'd0;
                        end else begin
                            r_dreq_valid  <= 1'b1;
                            r_dreq_addr   <= req_addr;
                            r_dreq_strobe <= req_write ? f_strobe(req_size, req_addr[2:0]) : 8'd0;
                            r_dreq_data   <= req_write ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (r_state == S_REQ && dresp_addr_ok) begin
                        r_dreq_valid <= 1'b0;
                    end
                    // Data beat completes the access; a pending or same-cycle flush swallows the response.
                    if ((r_state == S_WAIT || dresp_addr_ok) && dresp_data_ok) begin
                        r_rsp_valid <= ~(r_discard | flush);
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_write ? 64'd0
                                               : f_load_extend(dresp_data, r_off, r_size, r_unsigned);
                    end
                end
                S_DONE:  r_discard <= 1'b0;
                default: r_discard <= 1'b0;
            endcase
        end
    end

    // Saturating count of cycles spent on the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy <= {CNT_W{1'b0}};
        end else if ((r_state == S_REQ || r_state == S_WAIT) && r_busy != {CNT_W{1'b1}}) begin
            r_busy <= r_busy + CNT_W'(1);
        end
    end

    assign stall       = (r_state == S_IDLE && w_accept) || r_state == S_REQ || r_state == S_WAIT;
    assign rsp_valid   = r_rsp_valid & ~flush;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign dreq_valid  = r_dreq_valid;
    assign dreq_addr   = r_dreq_addr;
    assign dreq_strobe = r_dreq_strobe;
    assign dreq_data   = r_dreq_data;
    assign busy_cycles = r_busy;

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: directed vector table, corner-case sequences and randomized accesses
// checked against a byte-level reference model of the data-bus controller.
module tb_dbus_ctrl;

    localparam int CNT_W    = 6;
    localparam int BUSY_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_write = 1'b0;
    logic [63:0]      req_addr = 64'd0;
    logic [1:0]       req_size = 2'd0;
    logic             req_unsigned = 1'b0;
    logic [63:0]      req_wdata = 64'd0;
    logic             flush = 1'b0;
    logic             stall;
    logic             rsp_valid;
    logic             rsp_err;
    logic [63:0]      rsp_rdata;
    logic             dreq_valid;
    logic [63:0]      dreq_addr;
    logic [7:0]       dreq_strobe;
    logic [63:0]      dreq_data;
    logic             dresp_addr_ok = 1'b0;
    logic             dresp_data_ok = 1'b0;
    logic [63:0]      dresp_data = 64'd0;
    logic [CNT_W-1:0] busy_cycles;

    dbus_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [63:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] wdata;
        logic [63:0] rdata;   // value the bus returns
        int          alat;    // REQ cycles before addr_ok
        int          dlat;    // cycles from addr_ok to data_ok
        int          fcyc;    // cycle after issue carrying flush, 0 = none
    } txn_t;

    typedef struct {
        logic [63:0] rdata;
        logic [7:0]  strobe;
        logic [63:0] data;
        bit          err;
        int          busy;
        int          pulses;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    typedef struct {
        int          lat;
        int          stall_cnt;
        int          nreq;
        int          pulses;
        int          busy;
        bit          stall_issue;
        bit          idle_ok;
        bit          unstable;
        bit          err;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;
    int model_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          nb;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        nb       = 1 << t.size;
        off      = int'(t.addr[2:0]);
        e.err    = (off % nb) != 0;
        e.busy   = e.err ? 0 : t.alat + 1 + t.dlat;
        e.pulses = (t.fcyc >= 1 && t.fcyc <= e.busy + 1) ? 0 : 1;
        e.strobe = 8'd0;
        e.data   = 64'd0;
        e.rdata  = 64'd0;
        if (!e.err && t.write) begin
            for (int b = 0; b < 8; b++) e.strobe[b] = (b >= off && b < off + nb);
            e.data = t.wdata << (8 * off);
        end else if (!e.err) begin
            mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
            v    = (t.rdata >> (8 * off)) & mask;
            if (!t.uns && v[8 * nb - 1]) v = v | ~mask;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req_valid = 1'b0; flush = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_busy = 0;
    endtask

    // Issue one access in the cycle after the previous one ended, play the bus side, observe.
    task automatic run(input txn_t t, output obs_t o);
        int  reqcnt;
        int  wcnt;
        bit  addr_done;
        bit  done;
        reqcnt = 0; wcnt = 0; addr_done = 1'b0; done = 1'b0;
        o.lat = 0; o.stall_cnt = 0; o.nreq = 0; o.pulses = 0; o.busy = 0;
        o.unstable = 1'b0; o.err = 1'b0; o.rdata = 64'd0;
        o.addr = 64'd0; o.strobe = 8'd0; o.data = 64'd0;
        @(negedge clk);
        o.idle_ok = !rsp_valid && !dreq_valid;
        req_valid = 1'b1; req_write = t.write; req_addr = t.addr; req_size = t.size;
        req_unsigned = t.uns; req_wdata = t.wdata; flush = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
        #1 o.stall_issue = stall;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
            dresp_data = {$urandom, $urandom};
            flush = (c == t.fcyc);
            if (dreq_valid) begin
                reqcnt++;
                if (reqcnt == 1) begin
                    o.addr = dreq_addr; o.strobe = dreq_strobe; o.data = dreq_data;
                end else if (dreq_addr !== o.addr || dreq_strobe !== o.strobe || dreq_data !== o.data) begin
                    o.unstable = 1'b1;
                end
                if (!addr_done && reqcnt == t.alat + 1) begin
                    dresp_addr_ok = 1'b1; addr_done = 1'b1;
                    if (t.dlat == 0) begin
                        dresp_data_ok = 1'b1; dresp_data = t.rdata;
                    end
                end
            end else if (addr_done && t.dlat > 0) begin
                wcnt++;
                if (wcnt == t.dlat) begin
                    dresp_data_ok = 1'b1; dresp_data = t.rdata;
                end
            end
            #1;
            if (rsp_valid) o.pulses++;
            if (stall) begin
                o.stall_cnt++;
            end else begin
                done = 1'b1; o.lat = c; o.err = rsp_err; o.rdata = rsp_rdata; o.busy = int'(busy_cycles);
            end
        end
        o.nreq = reqcnt;
    endtask

    task automatic check_txn(input string tag, input txn_t t, input exp_t e, input obs_t o);
        model_busy = (model_busy + e.busy > BUSY_MAX) ? BUSY_MAX : model_busy + e.busy;
        chk({tag, ".idle_before"}, o.idle_ok, 1'b1);
        chk({tag, ".stall_issue"}, o.stall_issue, 1'b1);
        chk({tag, ".latency"}, o.lat, e.busy + 1);
        chk({tag, ".stall_cycles"}, o.stall_cnt, e.busy);
        chk({tag, ".dreq_cycles"}, o.nreq, e.err ? 0 : t.alat + 1);
        chk({tag, ".dreq_stable"}, o.unstable, 1'b0);
        chk({tag, ".rsp_pulses"}, o.pulses, e.pulses);
        chk({tag, ".busy_cycles"}, o.busy, model_busy);
        if (!e.err) begin
            chk({tag, ".dreq_addr"}, o.addr, t.addr);
            chk({tag, ".dreq_strobe"}, o.strobe, e.strobe);
            chk({tag, ".dreq_data"}, o.data, e.data);
        end
        if (e.pulses != 0) begin
            chk({tag, ".rsp_err"}, o.err, e.err);
            chk({tag, ".rsp_rdata"}, o.rdata, e.rdata);
        end
        if (o.lat == 0) do_reset();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, stall, 1'b0);
        chk({tag, ".dreq_valid"}, dreq_valid, 1'b0);
        chk({tag, ".dreq_addr"}, dreq_addr, 64'd0);
        chk({tag, ".dreq_strobe"}, dreq_strobe, 8'd0);
        chk({tag, ".dreq_data"}, dreq_data, 64'd0);
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, ".rsp_err"}, rsp_err, 1'b0);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 64'd0);
        chk({tag, ".busy_cycles"}, busy_cycles, 6'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation reached %0t without finishing, limit 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        txn_t t;
        exp_t e;
        obs_t o;
        int   off;

        // write addr size uns wdata rdata alat dlat fcyc | rdata strobe data err busy pulses
        vecs[0]  = '{'{1'b0, 64'h1000, 2'd3, 1'b0, 64'h0, 64'h1122334455667788, 0, 0, 0},
                     '{64'h1122334455667788, 8'h00, 64'h0, 1'b0, 1, 1}};
        vecs[1]  = '{'{1'b0, 64'h1007, 2'd0, 1'b0, 64'h0, 64'h8000000000000000, 0, 0, 0},
                     '{64'hFFFFFFFFFFFFFF80, 8'h00, 64'h0, 1'b0, 1, 1}};
        vecs[2]  = '{'{1'b0, 64'h1007, 2'd0, 1'b1, 64'h0, 64'h8000000000000000, 0, 0, 0},
                     '{64'h0000000000000080, 8'h00, 64'h0, 1'b0, 1, 1}};
        vecs[3]  = '{'{1'b1, 64'h1002, 2'd1, 1'b0, 64'hBEEF, 64'h0, 3, 2, 0},
                     '{64'h0, 8'h0C, 64'h00000000BEEF0000, 1'b0, 6, 1}};
        vecs[4]  = '{'{1'b0, 64'h1001, 2'd2, 1'b0, 64'h0, 64'h0, 0, 0, 0},
                     '{64'h0, 8'h00, 64'h0, 1'b1, 0, 1}};
        vecs[5]  = '{'{1'b0, 64'h1004, 2'd2, 1'b0, 64'h0, 64'h8765432100000000, 1, 1, 0},
                     '{64'hFFFFFFFF87654321, 8'h00, 64'h0, 1'b0, 3, 1}};
        vecs[6]  = '{'{1'b0, 64'h1006, 2'd1, 1'b1, 64'h0, 64'hABCD000000000000, 0, 1, 0},
                     '{64'h000000000000ABCD, 8'h00, 64'h0, 1'b0, 2, 1}};
        vecs[7]  = '{'{1'b1, 64'h1003, 2'd0, 1'b0, 64'h5A, 64'h0, 0, 0, 0},
                     '{64'h0, 8'h08, 64'h000000005A000000, 1'b0, 1, 1}};
        vecs[8]  = '{'{1'b1, 64'h1004, 2'd3, 1'b0, 64'h1, 64'h0, 0, 0, 0},
                     '{64'h0, 8'h00, 64'h0, 1'b1, 0, 1}};
        vecs[9]  = '{'{1'b0, 64'h2000, 2'd3, 1'b0, 64'h0, 64'h55AA55AA55AA55AA, 0, 2, 2},
                     '{64'h0, 8'h00, 64'h0, 1'b0, 3, 0}};
        vecs[10] = '{'{1'b1, 64'h1004, 2'd2, 1'b0, 64'hDEADBEEF, 64'h0, 0, 2, 0},
                     '{64'h0, 8'hF0, 64'hDEADBEEF00000000, 1'b0, 3, 1}};
        vecs[11] = '{'{1'b0, 64'h1002, 2'd1, 1'b0, 64'h0, 64'h00000000F00D0000, 0, 0, 2},
                     '{64'h0, 8'h00, 64'h0, 1'b0, 1, 0}};

        // Reset state, both while held and just after release.
        @(negedge clk);
        #1 chk_all_zero("reset_held");
        do_reset();
        #1 chk_all_zero("reset_released");

        for (int i = 0; i < 12; i++) begin
            run(vecs[i].t, o);
            check_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
        end

        // flush alongside req_valid in IDLE: not accepted, no stall.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h4000; req_size = 2'd3; flush = 1'b1;
        #1 chk("idle_flush.stall", stall, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 chk("idle_flush.dreq_valid", dreq_valid, 1'b0);
        chk("idle_flush.rsp_valid", rsp_valid, 1'b0);

        // Reset pulse while the request is on the bus.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h3008; req_size = 2'd3; req_wdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_in_req.dreq_valid_before", dreq_valid, 1'b1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("rst_in_req");
        model_busy = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1 chk("rst_in_req.after_dreq_valid", dreq_valid, 1'b0);
        chk("rst_in_req.after_rsp_valid", rsp_valid, 1'b0);

        // Randomized accesses against the model; busy_cycles saturates along the way.
        for (int i = 0; i < 80; i++) begin
            t.write = 1'($urandom_range(0, 1));
            t.size  = 2'($urandom_range(0, 3));
            off     = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) off = off & ~((1 << t.size) - 1);
            t.addr  = {$urandom, $urandom};
            t.addr[2:0] = 3'(off);
            t.uns   = 1'($urandom_range(0, 1));
            t.wdata = {$urandom, $urandom};
            t.rdata = {$urandom, $urandom};
            t.alat  = $urandom_range(0, 3);
            t.dlat  = $urandom_range(0, 3);
            t.fcyc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            e = model(t);
            run(t, o);
            check_txn($sformatf("rnd%0d", i), t, e, o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
